// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_pkg
//  Purpose  : Opcodes, state encoding and datapath mux/ALU encodings shared by
//             the multi-cycle RV32I sequencer and its datapath.
//  Revision : 1.0  initial release
// ============================================================================
package multicycle_ctrl_pkg;

    // instr[6:2] major opcodes
    localparam logic [4:0] OPCODE_LOAD    = 5'b00000;
    localparam logic [4:0] OPCODE_STORE   = 5'b01000;
    localparam logic [4:0] OPCODE_BRANCH  = 5'b11000;
    localparam logic [4:0] OPCODE_JAL     = 5'b11011;
    localparam logic [4:0] OPCODE_JALR    = 5'b11001;
    localparam logic [4:0] OPCODE_ARITH_I = 5'b00100;
    localparam logic [4:0] OPCODE_ARITH_R = 5'b01100;
    localparam logic [4:0] OPCODE_LUI     = 5'b01101;
    localparam logic [4:0] OPCODE_AUIPC   = 5'b00101;
    localparam logic [4:0] OPCODE_SYSTEM  = 5'b11100;

    // 18 states do not fit the 4-bit debug port; terminals share code 4'hF there
    typedef enum logic [4:0] {
        ST_BOOT    = 5'd0,
        ST_FETCH   = 5'd1,
        ST_DECODE  = 5'd2,
        ST_EXEC_R  = 5'd3,
        ST_EXEC_I  = 5'd4,
        ST_ADDR    = 5'd5,
        ST_MEM_RD  = 5'd6,
        ST_MEM_WR  = 5'd7,
        ST_WB_MEM  = 5'd8,
        ST_WB_ALU  = 5'd9,
        ST_BRANCH  = 5'd10,
        ST_JAL     = 5'd11,
        ST_JALR    = 5'd12,
        ST_LUI     = 5'd13,
        ST_AUIPC   = 5'd14,
        ST_HALT    = 5'd15,
        ST_ILLEGAL = 5'd16,
        ST_FAULT   = 5'd17
    } state_e;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_RFUNCT = 2'b10;
    localparam logic [1:0] ALU_IFUNCT = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] WB_ALUOUT  = 2'b00;
    localparam logic [1:0] WB_MDR     = 2'b01;
    localparam logic [1:0] WB_PC4     = 2'b10;

    localparam logic [1:0] PC_ALU     = 2'b00;
    localparam logic [1:0] PC_ALUOUT  = 2'b01;
    localparam logic [1:0] PC_JALR    = 2'b10;

    function automatic logic is_terminal(input state_e s);
        return (s == ST_HALT) || (s == ST_ILLEGAL) || (s == ST_FAULT);
    endfunction

    function automatic logic [3:0] state_dbg_f(input state_e s);
        logic [4:0] v;
        v = s;
        return is_terminal(s) ? 4'hF : v[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_if
//  Purpose  : Control/status bundle between the sequencer (master) and the
//             shared datapath plus unified memory (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       op;
    logic             branch_taken;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             mem_addr_sel;
    logic             ir_write;
    logic             mdr_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             oldpc_write;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             aluout_write;
    logic             reg_write;
    logic [1:0]       wb_sel;
    logic             illegal;
    logic             fault;
    logic             halted;
    logic [CNT_W-1:0] instret;
    logic [3:0]       state_dbg;

    modport master (
        input  op, branch_taken, mem_ready,
        output mem_req, mem_we, mem_addr_sel, ir_write, mdr_write, pc_write,
               pc_src, oldpc_write, alu_src_a, alu_src_b, alu_op, aluout_write,
               reg_write, wb_sel, illegal, fault, halted, instret, state_dbg
    );

    modport slave (
        output op, branch_taken, mem_ready,
        input  mem_req, mem_we, mem_addr_sel, ir_write, mdr_write, pc_write,
               pc_src, oldpc_write, alu_src_a, alu_src_b, alu_op, aluout_write,
               reg_write, wb_sel, illegal, fault, halted, instret, state_dbg
    );
endinterface
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wait_timer
//  Purpose  : Counts consecutive stalled memory cycles and flags a timeout.
//  Revision : 1.0  initial release
// ============================================================================
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic ready_i,
    output logic timeout_o
);
    generate
        if (MEM_TIMEOUT != 0) begin : g_timer_on
            // Only 0..MEM_TIMEOUT-1 is ever held; the controller leaves on the next stall
            localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
            localparam logic [TW-1:0] LAST = TW'(MEM_TIMEOUT - 1);

            logic          stall;
            logic [TW-1:0] count_q;
            logic [TW-1:0] count_d;

            assign stall   = req_i & ~ready_i;
            assign count_d = stall ? count_q + TW'(1) : '0;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign timeout_o = stall && (count_q == LAST);
        end else begin : g_timer_off
            assign timeout_o = 1'b0;
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Purpose  : Multi-cycle RV32I sequencer: steps the shared datapath through
//             fetch/decode/execute/memory/writeback and counts retirements.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);
    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;
    logic             timeout;

    logic       mem_req, mem_we, mem_addr_sel, ir_write, mdr_write, pc_write;
    logic       oldpc_write, aluout_write, reg_write;
    logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (mem_req),
        .ready_i   (bus.mem_ready),
        .timeout_o (timeout)
    );

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        fault_d   = fault_q;
        retire    = 1'b0;
        case (state_q)
            ST_BOOT:   state_d = ST_FETCH;
            ST_FETCH: begin
                if (timeout) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else if (bus.mem_ready) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (bus.op)
                    OPCODE_ARITH_R:            state_d = ST_EXEC_R;
                    OPCODE_ARITH_I:            state_d = ST_EXEC_I;
                    OPCODE_LOAD, OPCODE_STORE: state_d = ST_ADDR;
                    OPCODE_BRANCH:             state_d = ST_BRANCH;
                    OPCODE_JAL:                state_d = ST_JAL;
                    OPCODE_JALR:               state_d = ST_JALR;
                    OPCODE_LUI:                state_d = ST_LUI;
                    OPCODE_AUIPC:              state_d = ST_AUIPC;
                    OPCODE_SYSTEM:             state_d = ST_HALT;
                    default: begin
                        state_d   = ST_ILLEGAL;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_EXEC_R, ST_EXEC_I, ST_LUI, ST_AUIPC: state_d = ST_WB_ALU;
            // IR still holds the instruction, so op separates load from store
            ST_ADDR:   state_d = (bus.op == OPCODE_STORE) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (timeout) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else if (bus.mem_ready) begin
                    state_d = ST_WB_MEM;
                end
            end
            ST_MEM_WR: begin
                if (timeout) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else if (bus.mem_ready) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end
            ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JAL, ST_JALR: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            default:   state_d = state_q;
        endcase
        instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            fault_q   <= fault_d;
            instret_q <= instret_d;
        end
    end

    // Transfer-completion strobes are qualified by mem_ready so stalls have no side effects
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        mdr_write    = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_ALU;
        oldpc_write  = 1'b0;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_RS2;
        alu_op       = ALU_ADD;
        aluout_write = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = WB_ALUOUT;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_write    = 1'b1;
                    oldpc_write = 1'b1;
                    pc_write    = 1'b1;
                    alu_src_b   = SRCB_FOUR;
                end
            end
            ST_DECODE: begin
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_IMM;
                aluout_write = 1'b1;
            end
            ST_EXEC_R: begin
                alu_src_a    = SRCA_RS1;
                alu_op       = ALU_RFUNCT;
                aluout_write = 1'b1;
            end
            ST_EXEC_I: begin
                alu_src_a    = SRCA_RS1;
                alu_src_b    = SRCB_IMM;
                alu_op       = ALU_IFUNCT;
                aluout_write = 1'b1;
            end
            ST_LUI: begin
                alu_src_a    = SRCA_ZERO;
                alu_src_b    = SRCB_IMM;
                aluout_write = 1'b1;
            end
            ST_AUIPC: begin
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_IMM;
                aluout_write = 1'b1;
            end
            ST_ADDR: begin
                alu_src_a    = SRCA_RS1;
                alu_src_b    = SRCB_IMM;
                aluout_write = 1'b1;
            end
            ST_MEM_RD: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mdr_write    = bus.mem_ready;
            end
            ST_MEM_WR: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr_sel = 1'b1;
            end
            ST_WB_ALU: reg_write = 1'b1;
            ST_WB_MEM: begin
                reg_write = 1'b1;
                wb_sel    = WB_MDR;
            end
            ST_BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALU_BRANCH;
                pc_write  = bus.branch_taken;
                pc_src    = PC_ALUOUT;
            end
            ST_JAL: begin
                pc_write  = 1'b1;
                pc_src    = PC_ALUOUT;
                reg_write = 1'b1;
                wb_sel    = WB_PC4;
            end
            ST_JALR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                pc_write  = 1'b1;
                pc_src    = PC_JALR;
                reg_write = 1'b1;
                wb_sel    = WB_PC4;
            end
            default: ;
        endcase
    end

    assign bus.mem_req      = mem_req;
    assign bus.mem_we       = mem_we;
    assign bus.mem_addr_sel = mem_addr_sel;
    assign bus.ir_write     = ir_write;
    assign bus.mdr_write    = mdr_write;
    assign bus.pc_write     = pc_write;
    assign bus.pc_src       = pc_src;
    assign bus.oldpc_write  = oldpc_write;
    assign bus.alu_src_a    = alu_src_a;
    assign bus.alu_src_b    = alu_src_b;
    assign bus.alu_op       = alu_op;
    assign bus.aluout_write = aluout_write;
    assign bus.reg_write    = reg_write;
    assign bus.wb_sel       = wb_sel;
    assign bus.illegal      = illegal_q;
    assign bus.fault        = fault_q;
    assign bus.halted       = is_terminal(state_q);
    assign bus.instret      = instret_q;
    assign bus.state_dbg    = state_dbg_f(state_q);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_ctrl
//  Purpose  : Scoreboard bench for multicycle_ctrl (MEM_TIMEOUT = 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(32)) bus ();

    multicycle_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic        exp_illegal = 1'b0;
    logic        exp_fault   = 1'b0;
    logic [31:0] exp_instret = '0;

    logic [25:0] exp_ctrl_q[$];
    logic [31:0] exp_cnt_q[$];
    string       tag_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] tb_dbg(input state_e st);
        logic [4:0] v;
        v = st;
        if (st == ST_HALT || st == ST_ILLEGAL || st == ST_FAULT) return 4'hF;
        return v[3:0];
    endfunction

    // Expected control word for one cycle in state st, straight from the state table
    function automatic logic [25:0] exp_vec(input state_e st, input logic rdy, input logic tk);
        logic       req, we, asel, irw, mdrw, pcw, oldw, aluw, regw, hlt;
        logic [1:0] pcs, sa, sb, aop, wbs;
        {req, we, asel, irw, mdrw, pcw, oldw, aluw, regw, hlt} = '0;
        {pcs, sa, sb, aop, wbs} = '0;
        case (st)
            ST_FETCH:  begin req = 1; irw = rdy; oldw = rdy; pcw = rdy; sb = rdy ? 2'b10 : 2'b00; end
            ST_DECODE: begin sa = 2'b10; sb = 2'b01; aluw = 1; end
            ST_EXEC_R: begin sa = 2'b01; sb = 2'b00; aop = 2'b10; aluw = 1; end
            ST_EXEC_I: begin sa = 2'b01; sb = 2'b01; aop = 2'b11; aluw = 1; end
            ST_LUI:    begin sa = 2'b11; sb = 2'b01; aluw = 1; end
            ST_AUIPC:  begin sa = 2'b10; sb = 2'b01; aluw = 1; end
            ST_ADDR:   begin sa = 2'b01; sb = 2'b01; aluw = 1; end
            ST_MEM_RD: begin req = 1; asel = 1; mdrw = rdy; end
            ST_MEM_WR: begin req = 1; we = 1; asel = 1; end
            ST_WB_ALU: begin regw = 1; wbs = 2'b00; end
            ST_WB_MEM: begin regw = 1; wbs = 2'b01; end
            ST_BRANCH: begin sa = 2'b01; aop = 2'b01; pcw = tk; pcs = 2'b01; end
            ST_JAL:    begin pcw = 1; pcs = 2'b01; regw = 1; wbs = 2'b10; end
            ST_JALR:   begin sa = 2'b01; sb = 2'b01; pcw = 1; pcs = 2'b10; regw = 1; wbs = 2'b10; end
            ST_HALT, ST_ILLEGAL, ST_FAULT: hlt = 1;
            default: ;
        endcase
        return {req, we, asel, irw, mdrw, pcw, pcs, oldw, sa, sb, aop, aluw, regw, wbs,
                exp_illegal, exp_fault, hlt, tb_dbg(st)};
    endfunction

    // Entered at posedge+1: drive inputs, queue expectation, advance one cycle
    task automatic step(input state_e st, input logic rdy, input logic tk);
        bus.mem_ready    = rdy;
        bus.branch_taken = tk;
        exp_ctrl_q.push_back(exp_vec(st, rdy, tk));
        exp_cnt_q.push_back(exp_instret);
        tag_q.push_back(st.name());
        @(posedge clk);
        #1;
        if (rst_n && ((st inside {ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JAL, ST_JALR}) ||
                      (st == ST_MEM_WR && rdy)))
            exp_instret++;
    endtask

    always @(negedge clk) begin
        if (exp_ctrl_q.size() > 0) begin
            string       t;
            logic [25:0] e;
            logic [31:0] c;
            t = tag_q.pop_front();
            e = exp_ctrl_q.pop_front();
            c = exp_cnt_q.pop_front();
            check_eq({"ctrl ", t},
                     {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_write, bus.mdr_write,
                      bus.pc_write, bus.pc_src, bus.oldpc_write, bus.alu_src_a, bus.alu_src_b,
                      bus.alu_op, bus.aluout_write, bus.reg_write, bus.wb_sel, bus.illegal,
                      bus.fault, bus.halted, bus.state_dbg}, e);
            check_eq({"instret ", t}, bus.instret, c);
        end
    end

    task automatic run_instr(input logic [4:0] opv, input logic tk, input int fw, input int mw);
        bus.op = opv;
        repeat (fw) step(ST_FETCH, 1'b0, tk);
        step(ST_FETCH, 1'b1, tk);
        step(ST_DECODE, 1'b1, tk);
        case (opv)
            5'b01100: begin step(ST_EXEC_R, 1'b1, tk); step(ST_WB_ALU, 1'b1, tk); end
            5'b00100: begin step(ST_EXEC_I, 1'b1, tk); step(ST_WB_ALU, 1'b1, tk); end
            5'b01101: begin step(ST_LUI,    1'b1, tk); step(ST_WB_ALU, 1'b1, tk); end
            5'b00101: begin step(ST_AUIPC,  1'b1, tk); step(ST_WB_ALU, 1'b1, tk); end
            5'b00000: begin
                step(ST_ADDR, 1'b1, tk);
                repeat (mw) step(ST_MEM_RD, 1'b0, tk);
                step(ST_MEM_RD, 1'b1, tk);
                step(ST_WB_MEM, 1'b1, tk);
            end
            5'b01000: begin
                step(ST_ADDR, 1'b1, tk);
                repeat (mw) step(ST_MEM_WR, 1'b0, tk);
                step(ST_MEM_WR, 1'b1, tk);
            end
            5'b11000: step(ST_BRANCH, 1'b1, tk);
            5'b11011: step(ST_JAL,    1'b1, tk);
            5'b11001: step(ST_JALR,   1'b1, tk);
            5'b11100: repeat (3) step(ST_HALT, 1'b1, tk);
            default: begin
                exp_illegal = 1'b1;
                repeat (3) step(ST_ILLEGAL, 1'b1, tk);
            end
        endcase
    endtask

    // Asynchronous reset entered at posedge+1; two BOOT cycles then released
    task automatic do_reset();
        rst_n       = 1'b0;
        exp_illegal = 1'b0;
        exp_fault   = 1'b0;
        exp_instret = '0;
        step(ST_BOOT, 1'b1, 1'b0);
        rst_n = 1'b1;
        step(ST_BOOT, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        bus.op           = 5'b0;
        bus.mem_ready    = 1'b0;
        bus.branch_taken = 1'b0;
        @(posedge clk);
        #1;
        step(ST_BOOT, 1'b0, 1'b0);
        step(ST_BOOT, 1'b1, 1'b0);
        rst_n = 1'b1;
        step(ST_BOOT, 1'b1, 1'b0);

        run_instr(5'b01100, 1'b0, 0, 0);   // ADD
        run_instr(5'b00000, 1'b0, 0, 3);   // LW, 3 wait states
        run_instr(5'b11000, 1'b0, 0, 0);   // BEQ not taken
        run_instr(5'b11000, 1'b1, 0, 0);   // BEQ taken
        run_instr(5'b00100, 1'b0, 2, 0);   // ADDI, stalled fetch
        run_instr(5'b01101, 1'b0, 0, 0);   // LUI
        run_instr(5'b00101, 1'b0, 0, 0);   // AUIPC
        run_instr(5'b11011, 1'b0, 0, 0);   // JAL
        run_instr(5'b11001, 1'b0, 0, 0);   // JALR
        run_instr(5'b01000, 1'b0, 0, 2);   // SW, 2 wait states
        run_instr(5'b00000, 1'b0, 3, 0);   // LW, fetch stalls just under timeout

        // Reset dropped mid store: request must vanish without a clock edge
        bus.op = 5'b01000;
        step(ST_FETCH, 1'b1, 1'b0);
        step(ST_DECODE, 1'b1, 1'b0);
        step(ST_ADDR, 1'b1, 1'b0);
        bus.mem_ready = 1'b0;
        #1;
        check_eq("mem_wr_active", {bus.mem_req, bus.mem_we, bus.mem_addr_sel}, 3'b111);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_drop", {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.state_dbg},
                 {3'b000, tb_dbg(ST_BOOT)});
        check_eq("async_rst_instret", bus.instret, 32'd0);
        @(posedge clk);
        #1;
        do_reset();
        run_instr(5'b01100, 1'b0, 0, 0);

        run_instr(5'b11111, 1'b0, 0, 0);   // illegal opcode
        do_reset();

        run_instr(5'b01100, 1'b0, 0, 0);
        bus.op = 5'b01100;
        repeat (4) step(ST_FETCH, 1'b0, 1'b0);
        exp_fault = 1'b1;
        step(ST_FAULT, 1'b0, 1'b0);
        step(ST_FAULT, 1'b1, 1'b0);
        step(ST_FAULT, 1'b1, 1'b0);
        do_reset();

        run_instr(5'b00100, 1'b0, 0, 0);
        run_instr(5'b11100, 1'b0, 0, 0);   // SYSTEM -> HALT

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I core. Replaces single-cycle decode with a Moore FSM.
- Steps the shared datapath (PC, IR, register file, ALU, ALUOut, MDR) through fetch/decode/execute/memory/writeback.
- Drives a single-port unified memory with a req/ready handshake.
- Counts retired instructions and flags illegal opcodes.

Parameters:
- MEM_TIMEOUT, 255: max wait cycles for mem_ready before FAULT; 0 disables the timeout.
- CNT_W, 32: width of instret.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- op  in  5  instr[6:2] from IR
- branch_taken  in  1  branch comparator result (funct3 already applied)
- mem_ready  in  1  memory completes the transfer this cycle
- mem_req  out  1  memory request
- mem_we  out  1  1=write, 0=read
- mem_addr_sel  out  1  0=PC, 1=ALUOut
- ir_write  out  1  load IR from memory read data
- mdr_write  out  1  load MDR from memory read data
- pc_write  out  1  update PC
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=ALU result & ~1
- oldpc_write  out  1  latch current PC as old PC
- alu_src_a  out  2  00=PC, 01=rs1, 10=old PC, 11=zero
- alu_src_b  out  2  00=rs2, 01=imm, 10=const 4
- alu_op  out  2  00=add, 01=branch compare, 10=R funct, 11=I funct
- aluout_write  out  1  latch ALUOut
- reg_write  out  1  register file write enable
- wb_sel  out  2  00=ALUOut, 01=MDR, 10=old PC+4
- illegal  out  1  sticky, unknown opcode seen
- fault  out  1  sticky, memory timeout
- halted  out  1  in HALT, ILLEGAL or FAULT
- instret  out  CNT_W  retired-instruction count
- state_dbg  out  4  current state encoding

Behaviour:
- States: BOOT, FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_MEM, WB_ALU, BRANCH, JAL, JALR, LUI, AUIPC, HALT, ILLEGAL, FAULT.
- Outputs are decoded combinationally from the state register only. Every control not listed for a state is 0.
- Reset (rst_n=0, async): state=BOOT, instret=0, illegal=0, fault=0, wait counter=0. All outputs 0.
- BOOT: one cycle, then FETCH.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr_sel=0.
  - mem_addr_sel and mem_we are held stable while mem_req=1.
  - Transfer completes on the edge where mem_req and mem_ready are both 1. In that cycle also assert: ir_write=1, oldpc_write=1, pc_write=1, pc_src=00, alu_src_a=00, alu_src_b=10, alu_op=00.
  - Then go to DECODE.
- DECODE:
  - alu_src_a=10, alu_src_b=01, alu_op=00, aluout_write=1 (speculative branch/JAL target).
  - Next state by op:
    - 01100 -> EXEC_R
    - 00100 -> EXEC_I
    - 00000 or 01000 -> ADDR
    - 11000 -> BRANCH
    - 11011 -> JAL
    - 11001 -> JALR
    - 01101 -> LUI
    - 00101 -> AUIPC
    - 11100 -> HALT
    - anything else -> ILLEGAL, and set illegal.
- EXEC_R: a=01, b=00, alu_op=10, aluout_write=1 -> WB_ALU.
- EXEC_I: a=01, b=01, alu_op=11, aluout_write=1 -> WB_ALU.
- LUI: a=11, b=01, alu_op=00, aluout_write=1 -> WB_ALU.
- AUIPC: a=10, b=01, alu_op=00, aluout_write=1 -> WB_ALU.
- ADDR: a=01, b=01, alu_op=00, aluout_write=1. Load -> MEM_RD, store -> MEM_WR.
- MEM_RD: mem_req=1, mem_addr_sel=1, mdr_write=1 on the completing cycle -> WB_MEM.
- MEM_WR: mem_req=1, mem_we=1, mem_addr_sel=1. Retires on the completing cycle -> FETCH.
- WB_ALU: reg_write=1, wb_sel=00. Retire -> FETCH.
- WB_MEM: reg_write=1, wb_sel=01. Retire -> FETCH.
- BRANCH: a=01, b=00, alu_op=01. pc_write=branch_taken, pc_src=01. Retire -> FETCH.
- JAL: pc_write=1, pc_src=01, reg_write=1, wb_sel=10. Retire -> FETCH.
- JALR: a=01, b=01, alu_op=00, pc_write=1, pc_src=10, reg_write=1, wb_sel=10. Retire -> FETCH.
- Retire: instret increments by 1 on the retiring edge. It wraps modulo 2^CNT_W with no flag.
- CPI: ALU ops 4, loads 5, stores 4, branch/jumps 3, assuming zero memory wait states.
- Wait counter:
  - Counts consecutive cycles with mem_req=1 and mem_ready=0. Clears when the transfer completes.
  - If MEM_TIMEOUT!=0 and the count reaches MEM_TIMEOUT: go to FAULT, set fault, drop mem_req.
  - mem_ready while mem_req=0 is ignored.
- HALT, ILLEGAL and FAULT are terminal. Only reset leaves them. halted=1 in all three.
- Reset asserted mid-transfer drops mem_req immediately, asynchronously.

Decomposition:
- Shared package/header holds:
  - the OPCODE_* 5-bit constants: Load, Store, Branch, JAL, JALR, Arith_I, Arith_R, LUI, AUIPC, SYSTEM;
  - the state encoding;
  - the alu_op, alu_src_a/b, wb_sel and pc_src encodings.
- One sub-module, mem_wait_timer: the wait counter and timeout compare.

Test Plan:
- ADD (op=01100), mem_ready tied 1 -> FETCH, DECODE, EXEC_R, WB_ALU. reg_write=1 only in cycle 4; instret 0->1.
- LW (op=00000), mem_ready low 3 cycles in MEM_RD -> mem_req, mem_addr_sel=1, mem_we=0 held steady. mdr_write only on the ready cycle; 8 cycles total.
- BEQ, branch_taken=0 then a second BEQ with branch_taken=1 -> pc_write=0 / pc_write=1 with pc_src=01 in BRANCH. instret +1 each.
- op=11111 -> ILLEGAL after DECODE; illegal=1, halted=1. No mem_req afterwards until rst_n pulses low; then state BOOT, instret=0.
- MEM_TIMEOUT=4, mem_ready held 0 during FETCH -> FAULT on the 4th wait cycle; fault=1, mem_req=0.
- rst_n dropped mid MEM_WR -> mem_req and mem_we go 0 without a clock edge. Restart from BOOT to FETCH.
